// File: rtl/gcc_result_collector.sv
// Result sink for the GCC centroid interface: tags each READY strobe with a sequence
// number and buffers it in a first-word-fall-through FIFO with drop and stall flags.
module gcc_result_collector #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned SEQ_W   = 8,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     READY,
    input  logic [7:0]               Xc,
    input  logic [7:0]               Yc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_x,
    output logic [7:0]               out_y,
    output logic [SEQ_W-1:0]         out_seq,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     overflow,
    output logic [7:0]               drop_cnt,
    output logic                     timeout
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef struct packed {
        logic [7:0]       x;
        logic [7:0]       y;
        logic [SEQ_W-1:0] seq;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        drop_q, drop_d;
    logic [WD_W-1:0]   idle_q, idle_d;
    logic              timeout_q, timeout_d;
    logic              full_c, pop_c, push_c, drop_c;

    // Handshake decode and next-state computation
    always_comb begin
        full_c     = (level_q == LVL_W'(DEPTH));
        pop_c      = (level_q != '0) && out_ready;
        push_c     = READY && (!full_c || pop_c);
        drop_c     = READY && full_c && !pop_c;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        seq_d      = seq_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        idle_d     = idle_q;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            seq_d    = seq_q + SEQ_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        level_d = level_q + LVL_W'(push_c) - LVL_W'(pop_c);

        if (drop_c) begin
            overflow_d = 1'b1;
            if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end

        // Watchdog: any READY (kept or dropped) counts as activity; TIMEOUT=0 parks the counter
        if (READY) begin
            idle_d = '0;
        end else if (idle_q != WD_W'(TIMEOUT)) begin
            idle_d = idle_q + WD_W'(1);
        end
        timeout_d = timeout_q || ((TIMEOUT != 0) && (idle_d == WD_W'(TIMEOUT)));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            idle_q     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            idle_q     <= idle_d;
            timeout_q  <= timeout_d;
        end
    end

    // Storage is cleared on reset so the idle head reads as zero
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_c) begin
            mem_q[wr_ptr_q] <= '{x: Xc, y: Yc, seq: seq_q};
        end
    end

    assign out_valid = (level_q != '0);
    assign out_x     = mem_q[rd_ptr_q].x;
    assign out_y     = mem_q[rd_ptr_q].y;
    assign out_seq   = mem_q[rd_ptr_q].seq;
    assign level     = level_q;
    assign full      = full_c;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_gcc_result_collector.sv
// Bench for gcc_result_collector: scoreboard of tagged results plus a small flag model,
// a table of fill/drop/drain vectors and hand sequences for the multi-cycle cases.
module tb_gcc_result_collector;

    localparam int DEPTH = 8;
    localparam int SEQ_W = 8;
    localparam int TO    = 10;

    logic                   CLK = 1'b0;
    logic                   RESET;
    logic                   READY;
    logic [7:0]             Xc, Yc;
    logic                   out_valid, out_ready;
    logic [7:0]             out_x, out_y;
    logic [SEQ_W-1:0]       out_seq;
    logic [$clog2(DEPTH):0] level;
    logic                   full, overflow, timeout;
    logic [7:0]             drop_cnt;

    gcc_result_collector #(.DEPTH(DEPTH), .SEQ_W(SEQ_W), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RESET(RESET), .READY(READY), .Xc(Xc), .Yc(Yc),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
        .out_seq(out_seq), .level(level), .full(full), .overflow(overflow),
        .drop_cnt(drop_cnt), .timeout(timeout)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] seq;
    } item_t;

    typedef struct {
        bit         rdy;
        logic [7:0] x;
        logic [7:0] y;
        bit         ordy;
        int         e_level;
        bit         e_ovf;
        int         e_drop;
    } vec_t;

    item_t sb[$];
    vec_t  tv[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    m_seq, m_drop, m_idle;
    bit    m_ovf, m_to;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset(input bit rdy);
        RESET = 1'b1; READY = rdy; Xc = 8'h5A; Yc = 8'hA5; out_ready = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b0; READY = 1'b0;
        sb.delete();
        m_seq = 0; m_drop = 0; m_idle = 0; m_ovf = 0; m_to = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_x", out_x, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_out_seq", out_seq, 0);
        chk("rst_level", level, 0);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_timeout", timeout, 0);
    endtask

    // One clock: check the head against the scoreboard, advance the model, check flags
    task automatic step(input bit r, input logic [7:0] x, input logic [7:0] y, input bit ordy);
        bit    pop_e;
        item_t it;
        READY = r; Xc = x; Yc = y; out_ready = ordy;
        #1;
        pop_e = 0;
        chk("out_valid", int'(out_valid), int'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("head_x", out_x, sb[0].x);
            chk("head_y", out_y, sb[0].y);
            chk("head_seq", out_seq, sb[0].seq);
            pop_e = ordy;
        end
        @(posedge CLK);
        if (pop_e) void'(sb.pop_front());
        if (r) begin
            if (sb.size() < DEPTH) begin
                it.x = x; it.y = y; it.seq = 8'(m_seq);
                sb.push_back(it);
                m_seq = (m_seq + 1) % 256;
            end else begin
                m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end
            m_idle = 0;
        end else if (m_idle < TO) begin
            m_idle++;
        end
        if (m_idle == TO) m_to = 1;
        #1;
        chk("level", level, sb.size());
        chk("full", int'(full), int'(sb.size() == DEPTH));
        chk("overflow", overflow, m_ovf);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("timeout", timeout, m_to);
    endtask

    initial begin
        vec_t v;
        // Fill to full, drop one, drain, then one more accepted result
        for (int i = 0; i < 8; i++) begin
            v = '{1, 8'(i), 8'(255 - i), 0, i + 1, 0, 0};
            tv.push_back(v);
        end
        v = '{1, 8'h33, 8'h33, 0, 8, 1, 1};
        tv.push_back(v);
        for (int i = 0; i < 8; i++) begin
            v = '{0, 8'h00, 8'h00, 1, 7 - i, 1, 1};
            tv.push_back(v);
        end
        v = '{1, 8'h44, 8'h55, 0, 1, 1, 1};
        tv.push_back(v);

        // 1: single result through an empty FIFO
        do_reset(0);
        step(1, 8'h80, 8'h80, 1);
        chk("t1_valid", out_valid, 1);
        chk("t1_x", out_x, 8'h80);
        chk("t1_seq", out_seq, 0);
        step(0, 8'h00, 8'h00, 1);
        chk("t1_empty_valid", out_valid, 0);
        chk("t1_empty_level", level, 0);

        // 2: table-driven fill / drop / drain
        do_reset(0);
        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].rdy, tv[i].x, tv[i].y, tv[i].ordy);
            chk("tv_level", level, tv[i].e_level);
            chk("tv_overflow", overflow, tv[i].e_ovf);
            chk("tv_drop_cnt", drop_cnt, tv[i].e_drop);
        end
        chk("t2_seq_after_drop", out_seq, 8);
        step(0, 8'h00, 8'h00, 1);

        // 3: push and pop together while full
        do_reset(0);
        for (int i = 0; i < 8; i++) step(1, 8'(8'h10 + i), 8'(i), 0);
        chk("t3_full", full, 1);
        step(1, 8'hAA, 8'hBB, 1);
        chk("t3_level", level, 8);
        chk("t3_overflow", overflow, 0);
        for (int i = 0; i < 7; i++) step(0, 8'h00, 8'h00, 1);
        chk("t3_last_x", out_x, 8'hAA);
        chk("t3_last_seq", out_seq, 8);
        step(0, 8'h00, 8'h00, 1);

        // 4: sequence wrap over 300 results
        do_reset(0);
        for (int i = 0; i < 300; i++) step(1, 8'(i), 8'(255 - (i % 256)), 1);
        chk("t4_final_seq", out_seq, 43);
        chk("t4_overflow", overflow, 0);
        step(0, 8'h00, 8'h00, 1);

        // 5: watchdog fires after exactly TO idle cycles; sticky until reset
        do_reset(0);
        for (int i = 0; i < TO - 1; i++) step(0, 8'h00, 8'h00, 1);
        chk("t5_timeout_early", timeout, 0);
        step(0, 8'h00, 8'h00, 1);
        chk("t5_timeout_hit", timeout, 1);
        step(1, 8'h01, 8'h02, 1);
        chk("t5_timeout_sticky", timeout, 1);
        step(0, 8'h00, 8'h00, 1);
        do_reset(0);

        // 6: reset mid-operation with READY high in the reset cycle
        for (int i = 0; i < 8; i++) step(1, 8'(8'h20 + i), 8'(i), 0);
        step(1, 8'h99, 8'h99, 0);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 8'h00, 1);
        chk("t6_level5", level, 5);
        chk("t6_ovf", overflow, 1);
        do_reset(1);
        step(0, 8'h00, 8'h00, 0);
        chk("t6_not_captured", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
